// File: rtl/ahb_sram_bridge_wb_pkg.sv
// rtl/ahb_sram_bridge_wb_pkg.sv - shared AHB codes, FSM states and byte-mask helper for the bridge
package ahb_sram_bridge_wb_pkg;

   localparam logic [1:0] HTRANS_IDLE = 2'b00;
   localparam logic [1:0] HTRANS_BUSY = 2'b01;

   typedef enum logic [2:0] {
      S_IDLE,
      S_RD_HAZ,
      S_RD_REQ,
      S_RD_RSP,
      S_WR_DATA,
      S_WR_FULL,
      S_ERR1,
      S_ERR2
   } state_t;

   // Lanes touched by a transfer of 2**size bytes starting at byte offset; caller truncates to W_BE.
   function automatic logic [7:0] byte_mask(input logic [2:0] size, input logic [2:0] offset);
      logic [15:0] span;
      span = (16'd1 << (16'd1 << size)) - 16'd1;
      span = span << offset;
      return span[7:0];
   endfunction

endpackage

// File: rtl/ahb_wbuf.sv
// rtl/ahb_wbuf.sv - posted write FIFO with per-entry word-address hazard compare
module ahb_wbuf #(
   parameter int W_ADDR = 32,
   parameter int W_DATA = 32,
   parameter int DEPTH  = 4,
   parameter int W_BE   = W_DATA / 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              push,
   input  logic [W_ADDR-1:0] push_addr,
   input  logic [W_DATA-1:0] push_data,
   input  logic [W_BE-1:0]   push_mask,
   input  logic              pop,
   output logic [W_ADDR-1:0] head_addr,
   output logic [W_DATA-1:0] head_data,
   output logic [W_BE-1:0]   head_mask,
   output logic              empty,
   output logic              full,
   input  logic [W_ADDR-1:0] chk_addr,
   output logic              hazard
);

   localparam int W_PTR = $clog2(DEPTH) + 1;
   localparam int W_IDX = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [W_ADDR-1:0] addr_mem [DEPTH];
   logic [W_DATA-1:0] data_mem [DEPTH];
   logic [W_BE-1:0]   mask_mem [DEPTH];
   logic [DEPTH-1:0]  valid;
   logic [DEPTH-1:0]  match;
   logic [W_PTR-1:0]  wr_ptr;
   logic [W_PTR-1:0]  rd_ptr;
   logic [W_IDX-1:0]  wr_idx;
   logic [W_IDX-1:0]  rd_idx;
   logic              do_push;
   logic              do_pop;

   assign wr_idx  = W_IDX'(wr_ptr % W_PTR'(DEPTH));
   assign rd_idx  = W_IDX'(rd_ptr % W_PTR'(DEPTH));
   assign empty   = (wr_ptr == rd_ptr);
   assign full    = ((wr_ptr ^ rd_ptr) == W_PTR'(DEPTH));
   assign do_pop  = pop && !empty;
   // A pop in the same cycle frees the slot, so a full buffer still accepts the push.
   assign do_push = push && (!full || do_pop);

   assign head_addr = addr_mem[rd_idx];
   assign head_data = data_mem[rd_idx];
   assign head_mask = mask_mem[rd_idx];

   always_comb begin
      match = '0;
      for (int i = 0; i < DEPTH; i++) begin
         match[i] = valid[i] && (addr_mem[i] == chk_addr);
      end
   end

   assign hazard = (|match) || (do_push && (push_addr == chk_addr));

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         valid  <= '0;
      end else begin
         if (do_pop) begin
            rd_ptr         <= rd_ptr + W_PTR'(1);
            valid[rd_idx]  <= 1'b0;
         end
         if (do_push) begin
            wr_ptr         <= wr_ptr + W_PTR'(1);
            valid[wr_idx]  <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) begin
         addr_mem[wr_idx] <= push_addr;
         data_mem[wr_idx] <= push_data;
         mask_mem[wr_idx] <= push_mask;
      end
   end

endmodule

// File: rtl/ahb_sram_bridge_wb.sv
// rtl/ahb_sram_bridge_wb.sv - AHB-lite slave to cached-memory request port with posted write buffer
module ahb_sram_bridge_wb
   import ahb_sram_bridge_wb_pkg::*;
#(
   parameter int W_ADDR     = 32,
   parameter int W_DATA     = 32,
   parameter int WBUF_DEPTH = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   output logic                  ahbls_hready_resp,
   input  logic                  ahbls_hready,
   output logic                  ahbls_hresp,
   input  logic [W_ADDR-1:0]     ahbls_haddr,
   input  logic                  ahbls_hwrite,
   input  logic [1:0]            ahbls_htrans,
   input  logic [2:0]            ahbls_hsize,
   input  logic [W_DATA-1:0]     ahbls_hwdata,
   output logic [W_DATA-1:0]     ahbls_hrdata,
   output logic                  mem_req,
   output logic                  mem_we,
   output logic [W_ADDR-1:0]     mem_addr,
   output logic [W_DATA-1:0]     mem_wdata,
   output logic [W_DATA/8-1:0]   mem_wmask,
   input  logic                  mem_ack,
   input  logic [W_DATA-1:0]     mem_rdata
);

   localparam int W_BE  = W_DATA / 8;
   localparam int W_OFF = $clog2(W_BE);

   state_t            state;
   state_t            state_d;
   logic [W_ADDR-1:0] addr_q;
   logic [W_BE-1:0]   mask_q;
   logic [W_ADDR-1:0] haddr_word;
   logic [7:0]        mask_full;
   logic [W_BE-1:0]   mask_new;
   logic [W_OFF-1:0]  align_mask;
   logic              addr_err;
   logic              trans_active;
   logic              accept;
   logic              slot_free;
   logic              wr_phase;
   logic              can_push;
   logic              push;
   logic              pop;
   logic              rd_want;
   logic              rd_inflight;
   logic              port_free;
   logic              buf_empty;
   logic              buf_full;
   logic              hazard;
   logic [W_ADDR-1:0] chk_addr;
   logic [W_BE-1:0]   rd_mask;
   logic [W_ADDR-1:0] head_addr;
   logic [W_DATA-1:0] head_data;
   logic [W_BE-1:0]   head_mask;

   assign haddr_word   = {ahbls_haddr[W_ADDR-1:W_OFF], {W_OFF{1'b0}}};
   assign mask_full    = byte_mask(ahbls_hsize, 3'(ahbls_haddr[W_OFF-1:0]));
   assign mask_new     = mask_full[W_BE-1:0];
   assign align_mask   = W_OFF'((32'd1 << ahbls_hsize) - 32'd1);
   assign addr_err     = (ahbls_hsize > 3'(W_OFF)) || (|(ahbls_haddr[W_OFF-1:0] & align_mask));
   assign trans_active = (ahbls_htrans != HTRANS_IDLE) && (ahbls_htrans != HTRANS_BUSY);

   assign pop         = mem_req && mem_we && mem_ack;
   assign rd_inflight = mem_req && !mem_we;
   assign port_free   = !mem_req || mem_ack;
   assign wr_phase    = (state == S_WR_DATA) || (state == S_WR_FULL);
   assign can_push    = !buf_full || pop;
   assign push        = wr_phase && can_push;
   assign slot_free   = (state == S_IDLE) || (state == S_RD_RSP) || (state == S_ERR2) || push;
   assign accept      = slot_free && ahbls_hready && trans_active;
   // During the address phase the hazard check looks at the incoming address, afterwards at the held one.
   assign chk_addr    = accept ? haddr_word : addr_q;
   assign rd_mask     = accept ? mask_new : mask_q;

   ahb_wbuf #(
      .W_ADDR (W_ADDR),
      .W_DATA (W_DATA),
      .DEPTH  (WBUF_DEPTH)
   ) u_wbuf (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .push_addr (addr_q),
      .push_data (ahbls_hwdata),
      .push_mask (mask_q),
      .pop       (pop),
      .head_addr (head_addr),
      .head_data (head_data),
      .head_mask (head_mask),
      .empty     (buf_empty),
      .full      (buf_full),
      .chk_addr  (chk_addr),
      .hazard    (hazard)
   );

   always_comb begin
      state_d           = state;
      ahbls_hready_resp = 1'b1;
      ahbls_hresp       = 1'b0;
      rd_want           = 1'b0;
      case (state)
         S_IDLE, S_RD_RSP: ;
         S_RD_HAZ: begin
            ahbls_hready_resp = 1'b0;
            if (!hazard) begin
               rd_want = 1'b1;
               state_d = S_RD_REQ;
            end
         end
         S_RD_REQ: begin
            ahbls_hready_resp = 1'b0;
            rd_want           = !rd_inflight;
            if (rd_inflight && mem_ack) state_d = S_RD_RSP;
         end
         S_WR_DATA, S_WR_FULL: begin
            ahbls_hready_resp = can_push;
            if (!can_push) state_d = S_WR_FULL;
         end
         S_ERR1: begin
            ahbls_hready_resp = 1'b0;
            ahbls_hresp       = 1'b1;
            state_d           = S_ERR2;
         end
         S_ERR2: ahbls_hresp = 1'b1;
         default: state_d = S_IDLE;
      endcase
      if (slot_free) begin
         state_d = S_IDLE;
         if (accept) begin
            if (addr_err)          state_d = S_ERR1;
            else if (ahbls_hwrite) state_d = S_WR_DATA;
            else if (hazard)       state_d = S_RD_HAZ;
            else begin
               state_d = S_RD_REQ;
               rd_want = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= S_IDLE;
         addr_q       <= '0;
         mask_q       <= '0;
         ahbls_hrdata <= '0;
      end else begin
         state <= state_d;
         if (accept) begin
            addr_q <= haddr_word;
            mask_q <= mask_new;
         end
         if (state == S_RD_REQ && rd_inflight && mem_ack) ahbls_hrdata <= mem_rdata;
      end
   end

   // Request fields only change when the port is free, so they hold steady while mem_req is up.
   always_ff @(posedge clk) begin
      if (rst) begin
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         mem_wmask <= '0;
      end else if (port_free) begin
         if (rd_want) begin
            mem_req   <= 1'b1;
            mem_we    <= 1'b0;
            mem_addr  <= chk_addr;
            mem_wdata <= '0;
            mem_wmask <= rd_mask;
         end else if (!mem_req && !buf_empty) begin
            mem_req   <= 1'b1;
            mem_we    <= 1'b1;
            mem_addr  <= head_addr;
            mem_wdata <= head_data;
            mem_wmask <= head_mask;
         end else begin
            mem_req   <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_ahb_sram_bridge_wb.sv
// tb/tb_ahb_sram_bridge_wb.sv - directed self-checking bench for ahb_sram_bridge_wb
module tb_ahb_sram_bridge_wb;

   logic        clk = 1'b0;
   logic        rst;
   logic        ahbls_hready_resp;
   logic        ahbls_hready;
   logic        ahbls_hresp;
   logic [31:0] ahbls_haddr;
   logic        ahbls_hwrite;
   logic [1:0]  ahbls_htrans;
   logic [2:0]  ahbls_hsize;
   logic [31:0] ahbls_hwdata;
   logic [31:0] ahbls_hrdata;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_wmask;
   logic        mem_ack;
   logic [31:0] mem_rdata;

   int n_cmp = 0;
   int n_bad = 0;
   int n_req;
   logic [31:0] wd [5];

   always #5 clk = ~clk;
   assign ahbls_hready = ahbls_hready_resp;

   ahb_sram_bridge_wb #(
      .W_ADDR     (32),
      .W_DATA     (32),
      .WBUF_DEPTH (4)
   ) dut (
      .clk               (clk),
      .rst               (rst),
      .ahbls_hready_resp (ahbls_hready_resp),
      .ahbls_hready      (ahbls_hready),
      .ahbls_hresp       (ahbls_hresp),
      .ahbls_haddr       (ahbls_haddr),
      .ahbls_hwrite      (ahbls_hwrite),
      .ahbls_htrans      (ahbls_htrans),
      .ahbls_hsize       (ahbls_hsize),
      .ahbls_hwdata      (ahbls_hwdata),
      .ahbls_hrdata      (ahbls_hrdata),
      .mem_req           (mem_req),
      .mem_we            (mem_we),
      .mem_addr          (mem_addr),
      .mem_wdata         (mem_wdata),
      .mem_wmask         (mem_wmask),
      .mem_ack           (mem_ack),
      .mem_rdata         (mem_rdata)
   );

   task automatic expect_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic addr_phase(input logic wr, input logic [31:0] a, input logic [2:0] sz);
      ahbls_htrans = 2'b10;
      ahbls_hwrite = wr;
      ahbls_haddr  = a;
      ahbls_hsize  = sz;
   endtask

   task automatic bus_idle();
      ahbls_htrans = 2'b00;
      ahbls_hwrite = 1'b0;
   endtask

   task automatic mem_serve(input string tag, input logic we, input logic [31:0] a,
                            input logic [31:0] wdat, input logic [3:0] m, input logic [31:0] rdat);
      int n = 0;
      @(negedge clk);
      while (!mem_req && n < 30) begin
         @(negedge clk);
         n++;
      end
      expect_eq({tag, "_req"},   64'(mem_req),   64'(1'b1));
      expect_eq({tag, "_we"},    64'(mem_we),    64'(we));
      expect_eq({tag, "_addr"},  64'(mem_addr),  64'(a));
      expect_eq({tag, "_wdata"}, 64'(mem_wdata), 64'(wdat));
      expect_eq({tag, "_mask"},  64'(mem_wmask), 64'(m));
      mem_rdata = rdat;
      mem_ack   = 1'b1;
      step();
      mem_ack   = 1'b0;
   endtask

   task automatic count_req(input int cycles, output int n);
      n = 0;
      repeat (cycles) begin
         @(negedge clk);
         if (mem_req) n++;
      end
   endtask

   task automatic single_read(input string tag, input logic [31:0] a, input logic [31:0] d);
      addr_phase(1'b0, a, 3'd2);
      step();
      bus_idle();
      @(negedge clk);
      expect_eq({tag, "_wait_ready"}, 64'(ahbls_hready_resp), 64'(1'b0));
      expect_eq({tag, "_wait_resp"},  64'(ahbls_hresp),       64'(1'b0));
      expect_eq({tag, "_req"},        64'(mem_req),           64'(1'b1));
      expect_eq({tag, "_we"},         64'(mem_we),            64'(1'b0));
      expect_eq({tag, "_addr"},       64'(mem_addr),          64'(a));
      mem_rdata = d;
      mem_ack   = 1'b1;
      step();
      mem_ack   = 1'b0;
      @(negedge clk);
      expect_eq({tag, "_rsp_ready"},  64'(ahbls_hready_resp), 64'(1'b1));
      expect_eq({tag, "_rsp_resp"},   64'(ahbls_hresp),       64'(1'b0));
      expect_eq({tag, "_rdata"},      64'(ahbls_hrdata),      64'(d));
      expect_eq({tag, "_req_drop"},   64'(mem_req),           64'(1'b0));
      step();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not reach the summary");
      $fatal(1);
   end

   initial begin
      for (int i = 0; i < 5; i++) wd[i] = 32'hA500_0000 + 32'(i);
      rst          = 1'b1;
      ahbls_haddr  = '0;
      ahbls_hwrite = 1'b0;
      ahbls_htrans = 2'b00;
      ahbls_hsize  = 3'd2;
      ahbls_hwdata = '0;
      mem_ack      = 1'b0;
      mem_rdata    = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      expect_eq("rst_ready", 64'(ahbls_hready_resp), 64'(1'b1));
      expect_eq("rst_resp",  64'(ahbls_hresp),       64'(1'b0));
      expect_eq("rst_rdata", 64'(ahbls_hrdata),      64'(0));
      expect_eq("rst_req",   64'(mem_req),           64'(1'b0));
      expect_eq("rst_we",    64'(mem_we),            64'(1'b0));
      expect_eq("rst_addr",  64'(mem_addr),          64'(0));
      expect_eq("rst_wdata", 64'(mem_wdata),         64'(0));
      expect_eq("rst_mask",  64'(mem_wmask),         64'(0));
      step();
      rst = 1'b0;
      step();

      single_read("rd1", 32'h100, 32'hDEAD_BEEF);

      // Four posted writes fill the buffer, the fifth stalls until a pop.
      addr_phase(1'b1, 32'h0, 3'd2);
      for (int i = 0; i < 4; i++) begin
         step();
         ahbls_hwdata = wd[i];
         addr_phase(1'b1, 32'(4 * (i + 1)), 3'd2);
         @(negedge clk);
         expect_eq("wr_zero_wait", 64'(ahbls_hready_resp), 64'(1'b1));
      end
      step();
      ahbls_hwdata = wd[4];
      bus_idle();
      @(negedge clk);
      expect_eq("wr_full_stall0", 64'(ahbls_hready_resp), 64'(1'b0));
      step();
      @(negedge clk);
      expect_eq("wr_full_stall1", 64'(ahbls_hready_resp), 64'(1'b0));
      expect_eq("wr_head_req",    64'(mem_req),           64'(1'b1));
      expect_eq("wr_head_we",     64'(mem_we),            64'(1'b1));
      expect_eq("wr_head_addr",   64'(mem_addr),          64'(32'h0));
      expect_eq("wr_head_wdata",  64'(mem_wdata),         64'(wd[0]));
      mem_ack = 1'b1;
      #1;
      expect_eq("wr_full_release", 64'(ahbls_hready_resp), 64'(1'b1));
      step();
      mem_ack = 1'b0;
      for (int i = 1; i < 5; i++) mem_serve("wr_drain", 1'b1, 32'(4 * i), wd[i], 4'hF, 32'h0);
      count_req(6, n_req);
      expect_eq("wr_no_extra", 64'(n_req), 64'(0));
      step();

      // Byte write then overlapping read: the read must wait for the write to drain.
      addr_phase(1'b1, 32'h103, 3'd0);
      step();
      ahbls_hwdata = 32'hAA00_0000;
      addr_phase(1'b0, 32'h100, 3'd2);
      @(negedge clk);
      expect_eq("haz_wr_ready", 64'(ahbls_hready_resp), 64'(1'b1));
      step();
      bus_idle();
      @(negedge clk);
      expect_eq("haz_rd_wait",      64'(ahbls_hready_resp), 64'(1'b0));
      expect_eq("haz_no_early_req", 64'(mem_req),           64'(1'b0));
      mem_serve("haz_wr", 1'b1, 32'h100, 32'hAA00_0000, 4'b1000, 32'h0);
      mem_serve("haz_rd", 1'b0, 32'h100, 32'h0, 4'hF, 32'h1234_5678);
      @(negedge clk);
      expect_eq("haz_rsp_ready", 64'(ahbls_hready_resp), 64'(1'b1));
      expect_eq("haz_rsp_rdata", 64'(ahbls_hrdata),      64'(32'h1234_5678));
      step();

      // Non-matching read overtakes the buffered write.
      addr_phase(1'b1, 32'h200, 3'd2);
      step();
      ahbls_hwdata = 32'h0000_0055;
      addr_phase(1'b0, 32'h300, 3'd2);
      step();
      bus_idle();
      mem_serve("byp_rd", 1'b0, 32'h300, 32'h0, 4'hF, 32'hCAFE_F00D);
      @(negedge clk);
      expect_eq("byp_rsp_ready", 64'(ahbls_hready_resp), 64'(1'b1));
      expect_eq("byp_rsp_rdata", 64'(ahbls_hrdata),      64'(32'hCAFE_F00D));
      mem_serve("byp_wr", 1'b1, 32'h200, 32'h0000_0055, 4'hF, 32'h0);
      step();

      // Misaligned halfword write: two-cycle ERROR, nothing reaches memory.
      addr_phase(1'b1, 32'h101, 3'd1);
      step();
      ahbls_hwdata = 32'h0000_BEEF;
      bus_idle();
      @(negedge clk);
      expect_eq("err1_ready", 64'(ahbls_hready_resp), 64'(1'b0));
      expect_eq("err1_resp",  64'(ahbls_hresp),       64'(1'b1));
      step();
      @(negedge clk);
      expect_eq("err2_ready", 64'(ahbls_hready_resp), 64'(1'b1));
      expect_eq("err2_resp",  64'(ahbls_hresp),       64'(1'b1));
      step();
      @(negedge clk);
      expect_eq("err_done_resp", 64'(ahbls_hresp), 64'(1'b0));
      count_req(6, n_req);
      expect_eq("err_no_mem", 64'(n_req), 64'(0));
      step();

      // Reset with a write in flight and two entries buffered.
      addr_phase(1'b1, 32'h400, 3'd2);
      step();
      ahbls_hwdata = 32'h0000_1111;
      addr_phase(1'b1, 32'h404, 3'd2);
      step();
      ahbls_hwdata = 32'h0000_2222;
      bus_idle();
      step();
      @(negedge clk);
      expect_eq("rst_mid_req", 64'(mem_req), 64'(1'b1));
      rst = 1'b1;
      step();
      rst     = 1'b0;
      mem_ack = 1'b1;
      @(negedge clk);
      expect_eq("rst_mid_req_drop", 64'(mem_req),           64'(1'b0));
      expect_eq("rst_mid_ready",    64'(ahbls_hready_resp), 64'(1'b1));
      expect_eq("rst_mid_resp",     64'(ahbls_hresp),       64'(1'b0));
      step();
      mem_ack = 1'b0;
      count_req(6, n_req);
      expect_eq("rst_buf_empty", 64'(n_req), 64'(0));
      step();
      single_read("rd2", 32'h100, 32'hDEAD_BEEF);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
